// File: rtl/rom_chip_pkg.sv
// Shared constants for the 556PT5 (3604) / 556PT4 (3601) fuse PROM programmer:
// rail operation codes, result codes, FSM state encodings and chip widths.
package rom_chip_pkg;

    // operation[3:0] drives V4..V1; shared with the reader path
    localparam logic [3:0] OP_OFF  = 4'b0000;
    localparam logic [3:0] OP_READ = 4'b1100;
    localparam logic [3:0] OP_PROG = 4'b1110;

    typedef enum logic [1:0] {
        ST_OK              = 2'b00,
        ST_OVERBLOWN       = 2'b01,
        ST_RETRY_EXHAUSTED = 2'b10,
        ST_ABORTED         = 2'b11
    } status_e;

    typedef logic [2:0] state_t;

    localparam state_t S_IDLE    = 3'd0;
    localparam state_t S_READ    = 3'd1;
    localparam state_t S_EVAL    = 3'd2;
    localparam state_t S_SETUP   = 3'd3;
    localparam state_t S_PULSE   = 3'd4;
    localparam state_t S_RECOVER = 3'd5;
    localparam state_t S_DONE    = 3'd6;

    localparam int PT5_DATA_WIDTH    = 8;
    localparam int PT5_ADDRESS_WIDTH = 9;
    localparam int PT4_DATA_WIDTH    = 4;
    localparam int PT4_ADDRESS_WIDTH = 8;

    function automatic logic [3:0] op_for_state(input state_t s);
        logic [3:0] op;
        case (s)
            S_READ:  op = OP_READ;
            S_PULSE: op = OP_PROG;
            default: op = OP_OFF;
        endcase
        return op;
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/rom_programmer_if.sv
// Host command interface of the PROM programmer: one (address, data) command
// per valid/ready handshake plus abort, progress and result reporting.
interface rom_programmer_if
    import rom_chip_pkg::*;
#(
    parameter int DATA_WIDTH    = 8,
    parameter int ADDRESS_WIDTH = 9
);
    logic                     cmd_valid;
    logic                     cmd_ready;
    logic [ADDRESS_WIDTH-1:0] cmd_address;
    logic [DATA_WIDTH-1:0]    cmd_data;
    logic                     abort;
    logic                     busy;
    logic                     done;
    status_e                  status;

    modport master (
        output cmd_valid, cmd_address, cmd_data, abort,
        input  cmd_ready, busy, done, status
    );

    modport slave (
        input  cmd_valid, cmd_address, cmd_data, abort,
        output cmd_ready, busy, done, status
    );
endinterface

// File: rtl/rom_timer.sv
// Loadable down-counter; terminal is high while the count sits at zero.
// Loading N-1 on state entry makes the state last exactly N cycles.
module rom_timer #(
    parameter int WIDTH = 6
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic             terminal
);
    logic [WIDTH-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (reset) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - WIDTH'(1);
        end
    end

    assign terminal = (count_reg == '0);
endmodule

// File: rtl/rom_programmer.sv
// Fuse PROM word programmer: read-verify loop that pulses the lowest missing
// bit, retrying up to MAX_PULSES times per bit before giving up.
module rom_programmer
    import rom_chip_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int ADDRESS_WIDTH  = 9,
    parameter int SETUP_CYCLES   = 10,
    parameter int PULSE_CYCLES   = 50,
    parameter int RECOVER_CYCLES = 10,
    parameter int READ_CYCLES    = 4,
    parameter int MAX_PULSES     = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    rom_programmer_if.slave          host,
    output logic [3:0]               operation,
    output logic [ADDRESS_WIDTH-1:0] address_line,
    output logic [DATA_WIDTH-1:0]    data_line,
    output logic                     data_drive_en,
    input  logic [DATA_WIDTH-1:0]    data_line_in
);
    localparam int MAX_CYC = max4(SETUP_CYCLES, PULSE_CYCLES, RECOVER_CYCLES, READ_CYCLES);
    localparam int TIMER_W = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
    localparam int ATT_W   = $clog2(MAX_PULSES + 1);
    localparam int BIT_W   = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

    state_t                   state_reg, state_next;
    logic [ADDRESS_WIDTH-1:0] address_reg;
    logic [DATA_WIDTH-1:0]    target_reg;
    logic [DATA_WIDTH-1:0]    rb_reg;
    logic [DATA_WIDTH-1:0]    data_line_reg, data_line_next;
    logic [ATT_W-1:0]         attempts_reg, attempts_next;
    logic [BIT_W-1:0]         last_bit_reg, last_bit_next;
    logic                     abort_pend_reg, abort_pend_next;
    logic [3:0]               operation_reg;
    logic                     drive_reg;
    logic                     done_reg;
    status_e                  status_reg;
    status_e                  result;

    logic                     accept;
    logic                     timer_load;
    logic [TIMER_W-1:0]       timer_value;
    logic                     timer_done;

    logic [DATA_WIDTH-1:0]    pending;
    logic                     overblown;
    logic [BIT_W-1:0]         bit_idx;
    logic [ATT_W:0]           attempts_cand;
    logic [ATT_W-1:0]         attempts_sat;
    logic                     exhausted;

    rom_timer #(.WIDTH(TIMER_W)) u_timer (
        .clk        (clk),
        .reset      (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .terminal   (timer_done)
    );

    assign accept = (state_reg == S_IDLE) && host.cmd_valid;

    // Readback evaluation: bits set on chip but not wanted can never be undone.
    always_comb begin
        pending   = target_reg & ~rb_reg;
        overblown = |(rb_reg & ~target_reg);
        bit_idx   = '0;
        for (int k = DATA_WIDTH - 1; k >= 0; k--) begin
            if (pending[k]) bit_idx = BIT_W'(k);
        end
        if (bit_idx == last_bit_reg) begin
            attempts_cand = {1'b0, attempts_reg} + (ATT_W + 1)'(1);
        end else begin
            attempts_cand = (ATT_W + 1)'(1);
        end
        // Compare before saturating so the limit still trips when MAX_PULSES+1 is a power of two
        exhausted    = attempts_cand > (ATT_W + 1)'(MAX_PULSES);
        attempts_sat = attempts_cand[ATT_W] ? {ATT_W{1'b1}} : attempts_cand[ATT_W-1:0];
    end

    always_comb begin
        state_next      = state_reg;
        data_line_next  = data_line_reg;
        attempts_next   = attempts_reg;
        last_bit_next   = last_bit_reg;
        abort_pend_next = abort_pend_reg;
        result          = ST_OK;
        case (state_reg)
            S_IDLE: begin
                if (host.cmd_valid) begin
                    state_next      = S_READ;
                    attempts_next   = '0;
                    last_bit_next   = '0;
                    abort_pend_next = 1'b0;
                    data_line_next  = '0;
                end
            end
            S_READ: begin
                if (host.abort) begin
                    result     = ST_ABORTED;
                    state_next = S_DONE;
                end else if (timer_done) begin
                    state_next = S_EVAL;
                end
            end
            S_EVAL: begin
                if (host.abort) begin
                    result     = ST_ABORTED;
                    state_next = S_DONE;
                end else if (overblown) begin
                    result     = ST_OVERBLOWN;
                    state_next = S_DONE;
                end else if (pending == '0) begin
                    result     = ST_OK;
                    state_next = S_DONE;
                end else begin
                    last_bit_next = bit_idx;
                    attempts_next = attempts_sat;
                    if (exhausted) begin
                        result     = ST_RETRY_EXHAUSTED;
                        state_next = S_DONE;
                    end else begin
                        data_line_next = DATA_WIDTH'(1) << bit_idx;
                        state_next     = S_SETUP;
                    end
                end
            end
            S_SETUP, S_PULSE: begin
                // An abort still pays the full recovery time so the rails settle
                if (host.abort) begin
                    abort_pend_next = 1'b1;
                    data_line_next  = '0;
                    state_next      = S_RECOVER;
                end else if (timer_done) begin
                    if (state_reg == S_SETUP) begin
                        state_next = S_PULSE;
                    end else begin
                        data_line_next = '0;
                        state_next     = S_RECOVER;
                    end
                end
            end
            S_RECOVER: begin
                if (host.abort) abort_pend_next = 1'b1;
                if (timer_done) begin
                    if (abort_pend_reg || host.abort) begin
                        result     = ST_ABORTED;
                        state_next = S_DONE;
                    end else begin
                        state_next = S_READ;
                    end
                end
            end
            S_DONE: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    always_comb begin
        timer_load  = (state_next != state_reg);
        timer_value = '0;
        case (state_next)
            S_READ:    timer_value = TIMER_W'(READ_CYCLES - 1);
            S_SETUP:   timer_value = TIMER_W'(SETUP_CYCLES - 1);
            S_PULSE:   timer_value = TIMER_W'(PULSE_CYCLES - 1);
            S_RECOVER: timer_value = TIMER_W'(RECOVER_CYCLES - 1);
            default:   timer_value = '0;
        endcase
    end

    // Socket-side outputs are registered from state_next so the rails never glitch
    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg      <= S_IDLE;
            address_reg    <= '0;
            target_reg     <= '0;
            rb_reg         <= '0;
            data_line_reg  <= '0;
            attempts_reg   <= '0;
            last_bit_reg   <= '0;
            abort_pend_reg <= 1'b0;
            operation_reg  <= OP_OFF;
            drive_reg      <= 1'b0;
            done_reg       <= 1'b0;
            status_reg     <= ST_OK;
        end else begin
            state_reg      <= state_next;
            data_line_reg  <= data_line_next;
            attempts_reg   <= attempts_next;
            last_bit_reg   <= last_bit_next;
            abort_pend_reg <= abort_pend_next;
            if (accept) begin
                address_reg <= host.cmd_address;
                target_reg  <= host.cmd_data;
            end
            if ((state_reg == S_READ) && timer_done) begin
                rb_reg <= data_line_in;
            end
            operation_reg <= op_for_state(state_next);
            drive_reg     <= (state_next == S_SETUP) || (state_next == S_PULSE);
            done_reg      <= (state_next == S_DONE);
            if (state_next == S_DONE) begin
                status_reg <= result;
            end
        end
    end

    assign host.cmd_ready = (state_reg == S_IDLE);
    assign host.busy      = (state_reg != S_IDLE);
    assign host.done      = done_reg;
    assign host.status    = status_reg;
    assign operation      = operation_reg;
    assign address_line   = address_reg;
    assign data_line      = data_line_reg;
    assign data_drive_en  = drive_reg;
endmodule

// File: tb/tb_rom_programmer.sv
// Directed bench for rom_programmer with a behavioural fuse-chip model and a
// status scoreboard filled at command issue and drained on each done pulse.
module tb_rom_programmer;
    import rom_chip_pkg::*;

    localparam int DW  = 8;
    localparam int AW  = 9;
    localparam int SET = 2;
    localparam int PUL = 4;
    localparam int REC = 2;
    localparam int RD  = 2;
    localparam int MAXP = 3;

    logic          clk;
    logic          reset;
    logic [3:0]    operation;
    logic [AW-1:0] address_line;
    logic [DW-1:0] data_line;
    logic          data_drive_en;
    logic [DW-1:0] data_line_in;

    rom_programmer_if #(.DATA_WIDTH(DW), .ADDRESS_WIDTH(AW)) host ();

    rom_programmer #(
        .DATA_WIDTH     (DW),
        .ADDRESS_WIDTH  (AW),
        .SETUP_CYCLES   (SET),
        .PULSE_CYCLES   (PUL),
        .RECOVER_CYCLES (REC),
        .READ_CYCLES    (RD),
        .MAX_PULSES     (MAXP)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .host          (host),
        .operation     (operation),
        .address_line  (address_line),
        .data_line     (data_line),
        .data_drive_en (data_drive_en),
        .data_line_in  (data_line_in)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int accept_cyc;
    int done_cyc;

    status_e        sb_q[$];
    logic [DW-1:0]  pulse_q[$];
    int             prog_cycles;
    int             windows;
    logic           prev_prog;

    // Chip model: base pattern plus fuses blown by earlier pulses of this command
    logic [DW-1:0]  model_base;
    logic [DW-1:0]  model_blown;
    bit             model_blows;
    assign data_line_in = model_base | model_blown;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (host.cmd_valid && host.cmd_ready)
            model_blown <= '0;
        else if (model_blows && operation == OP_PROG && data_drive_en)
            model_blown <= model_blown | data_line;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // Pulse monitor: every OP_PROG cycle must have drivers on and a one-hot bit
    always @(negedge clk) begin
        if (operation == OP_PROG) begin
            prog_cycles++;
            if (!prev_prog) begin
                windows++;
                pulse_q.push_back(data_line);
            end
            check("prog_drive_en", 32'(data_drive_en), 32'd1);
            check("prog_onehot", 32'($onehot(data_line)), 32'd1);
        end
        prev_prog = (operation == OP_PROG);
    end

    // Scoreboard drain on done
    always @(negedge clk) begin
        if (host.done) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_done observed=done expected=no_done");
            end else begin
                check("status_at_done", 32'(host.status), 32'(sb_q.pop_front()));
            end
        end
    end

    task automatic clear_mon();
        prog_cycles = 0;
        windows     = 0;
        pulse_q.delete();
    endtask

    task automatic issue(input logic [AW-1:0] a, input logic [DW-1:0] d,
                         input bit push, input status_e exp);
        check("ready_before_cmd", 32'(host.cmd_ready), 32'd1);
        host.cmd_valid   = 1'b1;
        host.cmd_address = a;
        host.cmd_data    = d;
        if (push) sb_q.push_back(exp);
        @(negedge clk);
        accept_cyc     = cyc;
        host.cmd_valid = 1'b0;
        check("address_line", 32'(address_line), 32'(a));
        check("busy_after_accept", 32'(host.busy), 32'd1);
    endtask

    task automatic wait_done(input int bound, input string tag);
        bit seen = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (host.done) begin
                seen = 1;
                break;
            end
        end
        done_cyc = cyc;
        check(tag, 32'(seen), 32'd1);
    endtask

    task automatic wait_prog(input int bound, input string tag);
        bit seen = 0;
        for (int i = 0; i < bound; i++) begin
            @(negedge clk);
            if (operation == OP_PROG) begin
                seen = 1;
                break;
            end
        end
        check(tag, 32'(seen), 32'd1);
    endtask

    initial begin
        reset            = 1'b1;
        host.cmd_valid   = 1'b0;
        host.cmd_address = '0;
        host.cmd_data    = '0;
        host.abort       = 1'b0;
        model_base       = '0;
        model_blown      = '0;
        model_blows      = 0;
        prev_prog        = 1'b0;
        clear_mon();
        repeat (3) @(negedge clk);
        reset = 1'b0;
        check("rst_operation", 32'(operation), 32'(OP_OFF));
        check("rst_drive_en", 32'(data_drive_en), 32'd0);
        check("rst_data_line", 32'(data_line), 32'd0);
        check("rst_address_line", 32'(address_line), 32'd0);
        check("rst_cmd_ready", 32'(host.cmd_ready), 32'd1);
        check("rst_busy", 32'(host.busy), 32'd0);
        check("rst_done", 32'(host.done), 32'd0);
        check("rst_status", 32'(host.status), 32'(ST_OK));
        $display("step reset: initial state checked");

        // 1: reset during PULSE, no done expected
        issue(9'h020, 8'h10, 0, ST_OK);
        wait_prog(50, "t1_reach_pulse");
        reset = 1'b1;
        @(negedge clk);
        check("t1_operation", 32'(operation), 32'(OP_OFF));
        check("t1_drive_en", 32'(data_drive_en), 32'd0);
        check("t1_cmd_ready", 32'(host.cmd_ready), 32'd1);
        check("t1_busy", 32'(host.busy), 32'd0);
        check("t1_status", 32'(host.status), 32'(ST_OK));
        check("t1_done", 32'(host.done), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("t1_done_after", 32'(host.done), 32'd0);
        $display("step 1: reset mid-pulse");

        // 2: word already correct
        clear_mon();
        model_base = 8'h3C;
        issue(9'h1A5, 8'h3C, 1, ST_OK);
        wait_done(50, "t2_done_seen");
        check("t2_latency", 32'(done_cyc - accept_cyc + 1), 32'(RD + 2));
        check("t2_prog_cycles", 32'(prog_cycles), 32'd0);
        @(negedge clk);
        check("t2_ready_after", 32'(host.cmd_ready), 32'd1);
        check("t2_status_held", 32'(host.status), 32'(ST_OK));
        $display("step 2: cmd 0x1A5/0x3C latency %0d", done_cyc - accept_cyc + 1);

        // 3: blank word, each pulse blows its bit
        clear_mon();
        model_base  = 8'h00;
        model_blows = 1;
        issue(9'h000, 8'h05, 1, ST_OK);
        wait_done(300, "t3_done_seen");
        check("t3_windows", 32'(windows), 32'd2);
        check("t3_prog_cycles", 32'(prog_cycles), 32'(2 * PUL));
        if (pulse_q.size() >= 2) begin
            check("t3_first_bit", 32'(pulse_q[0]), 32'h01);
            check("t3_second_bit", 32'(pulse_q[1]), 32'h04);
        end
        model_blows = 0;
        @(negedge clk);
        $display("step 3: cmd 0x000/0x05 windows %0d", windows);

        // 4: extra fuse already blown
        clear_mon();
        model_base = 8'h81;
        issue(9'h010, 8'h01, 1, ST_OVERBLOWN);
        wait_done(50, "t4_done_seen");
        check("t4_prog_cycles", 32'(prog_cycles), 32'd0);
        @(negedge clk);
        $display("step 4: cmd 0x010/0x01 overblown");

        // 5: fuse never blows
        clear_mon();
        model_base = 8'h00;
        issue(9'h020, 8'h10, 1, ST_RETRY_EXHAUSTED);
        wait_done(500, "t5_done_seen");
        check("t5_windows", 32'(windows), 32'(MAXP));
        check("t5_prog_cycles", 32'(prog_cycles), 32'(MAXP * PUL));
        foreach (pulse_q[k]) check("t5_bit", 32'(pulse_q[k]), 32'h10);
        @(negedge clk);
        $display("step 5: cmd 0x020/0x10 windows %0d", windows);

        // 6: abort in second pulse cycle
        clear_mon();
        issue(9'h033, 8'h02, 1, ST_ABORTED);
        wait_prog(50, "t6_reach_pulse");
        @(negedge clk);
        host.abort = 1'b1;
        @(negedge clk);
        host.abort = 1'b0;
        check("t6_op_off", 32'(operation), 32'(OP_OFF));
        check("t6_drive_off", 32'(data_drive_en), 32'd0);
        check("t6_data_line", 32'(data_line), 32'd0);
        check("t6_done_early", 32'(host.done), 32'd0);
        @(negedge clk);
        check("t6_rec2_drive", 32'(data_drive_en), 32'd0);
        check("t6_rec2_done", 32'(host.done), 32'd0);
        @(negedge clk);
        check("t6_done", 32'(host.done), 32'd1);
        @(negedge clk);
        check("t6_ready_after", 32'(host.cmd_ready), 32'd1);
        check("t6_prog_cycles", 32'(prog_cycles), 32'd2);
        $display("step 6: abort in pulse");

        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
